// File: rtl/fft_addr_sequencer.sv
// Radix-2 in-place FFT schedule sequencer: walks stages/pairs, inserts drain bubbles, reports busy/done.
// Optional cycle_count performance counter enabled by defining FFT_ADDR_SEQ_PERF_EN.
module fft_addr_sequencer #(
  parameter int N             = 32,
  parameter int DRAIN_CYCLES  = 4,
  parameter int stage_width   = $clog2($clog2(N)),
  parameter int pair_id_width = $clog2(N / 2)
`ifdef FFT_ADDR_SEQ_PERF_EN
  ,
  parameter int CNT_WIDTH     = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic                     o_valid,
  output logic [stage_width-1:0]   stage,
  output logic [pair_id_width-1:0] pair_id
`ifdef FFT_ADDR_SEQ_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]     cycle_count
`endif
);

  localparam int LOG2N = $clog2(N);
  localparam int GW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [stage_width-1:0]   LAST_S   = stage_width'(LOG2N - 1);
  localparam logic [pair_id_width-1:0] LAST_P   = pair_id_width'(N / 2 - 1);
  localparam logic [GW-1:0]            GAP_LOAD = GW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [stage_width-1:0]   s_q, s_d;
  logic [pair_id_width-1:0] p_q, p_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [stage_width-1:0]   stage_q, stage_d;
  logic [pair_id_width-1:0] pair_q, pair_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    stage_d = stage_q;
    pair_d  = pair_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          p_d     = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          valid_d = 1'b1;
          stage_d = s_q;
          pair_d  = p_q;
          if (p_q != LAST_P) begin
            p_d = p_q + 1'b1;
          end else begin
            p_d = '0;
            // gap counter is loaded with DRAIN_CYCLES-1 so the bubble lasts exactly DRAIN_CYCLES edges
            if (s_q != LAST_S) begin
              s_d = s_q + 1'b1;
              if (DRAIN_CYCLES != 0) begin
                state_d = ST_DRAIN;
                gap_d   = GAP_LOAD;
              end
            end else if (DRAIN_CYCLES == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_FLUSH;
              gap_d   = GAP_LOAD;
            end
          end
        end
      end
      ST_DRAIN, ST_FLUSH: begin
        if (gap_q == '0) begin
          state_d = (state_q == ST_DRAIN) ? ST_RUN : ST_DONE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      p_q     <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      pair_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign o_valid = valid_q;
  assign stage   = stage_q;
  assign pair_id = pair_q;

`ifdef FFT_ADDR_SEQ_PERF_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // counts every edge taken outside IDLE, which spans acceptance+1 through the done edge
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      if (start) cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Scoreboard bench for fft_addr_sequencer: three configurations (N/DRAIN = 8/2, 8/0, 32/4).
// Expected issues/done edges come from a schedule model; a monitor compares as outputs appear.
module tb_fft_addr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] start_v, hold_v, rst_v;
  logic [2:0] val_v, busy_v, done_v;
  logic [1:0] st0, pr0, st1, pr1;
  logic [2:0] st2;
  logic [3:0] pr2;
  int stg[3];
  int pr[3];

  assign stg[0] = 32'(st0);
  assign stg[1] = 32'(st1);
  assign stg[2] = 32'(st2);
  assign pr[0]  = 32'(pr0);
  assign pr[1]  = 32'(pr1);
  assign pr[2]  = 32'(pr2);

`ifdef FFT_ADDR_SEQ_PERF_EN
  logic [15:0] cc0, cc1, cc2;
  int cnt[3];
  assign cnt[0] = 32'(cc0);
  assign cnt[1] = 32'(cc1);
  assign cnt[2] = 32'(cc2);
`endif

  fft_addr_sequencer #(.N(8), .DRAIN_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .hold(hold_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .o_valid(val_v[0]), .stage(st0), .pair_id(pr0)
`ifdef FFT_ADDR_SEQ_PERF_EN
    , .cycle_count(cc0)
`endif
  );

  fft_addr_sequencer #(.N(8), .DRAIN_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .hold(hold_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .o_valid(val_v[1]), .stage(st1), .pair_id(pr1)
`ifdef FFT_ADDR_SEQ_PERF_EN
    , .cycle_count(cc1)
`endif
  );

  fft_addr_sequencer #(.N(32), .DRAIN_CYCLES(4)) u_dut2 (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .hold(hold_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .o_valid(val_v[2]), .stage(st2), .pair_id(pr2)
`ifdef FFT_ADDR_SEQ_PERF_EN
    , .cycle_count(cc2)
`endif
  );

  typedef struct {int inst; int edge_n; int stage; int pair;} iss_t;
  typedef struct {int inst; int edge_n; int cnt;} dn_t;
  iss_t iq[$];
  dn_t  dq[$];

  int NN[3] = '{8, 8, 32};
  int DD[3] = '{2, 0, 4};
  int bfrom[3];
  int bto[3];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit end_req = 1'b0;
  logic [2:0] rst_s;
  int last_s[3];
  int last_p[3];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge; sole owner of the counters.
  always @(posedge clk) begin
    iss_t e;
    dn_t  d;
    cyc++;
    rst_s = rst_v;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst_s[i]) begin
        chk("rst_valid", int'(val_v[i]), 0);
        chk("rst_busy", int'(busy_v[i]), 0);
        chk("rst_done", int'(done_v[i]), 0);
        chk("rst_stage", stg[i], 0);
        chk("rst_pair", pr[i], 0);
`ifdef FFT_ADDR_SEQ_PERF_EN
        chk("rst_cycle_count", cnt[i], 0);
`endif
        last_s[i] = 0;
        last_p[i] = 0;
      end else begin
        chk("busy", int'(busy_v[i]), int'(cyc >= bfrom[i] && cyc <= bto[i]));
        if (val_v[i]) begin
          if (iq.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            e = iq.pop_front();
            chk("issue_inst", i, e.inst);
            chk("issue_edge", cyc, e.edge_n);
            chk("stage", stg[i], e.stage);
            chk("pair_id", pr[i], e.pair);
            last_s[i] = e.stage;
            last_p[i] = e.pair;
          end
        end else begin
          chk("stage_hold", stg[i], last_s[i]);
          chk("pair_hold", pr[i], last_p[i]);
        end
        if (done_v[i]) begin
          if (dq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            d = dq.pop_front();
            chk("done_inst", i, d.inst);
            chk("done_edge", cyc, d.edge_n);
`ifdef FFT_ADDR_SEQ_PERF_EN
            chk("cycle_count", cnt[i], d.cnt);
`endif
          end
        end
      end
    end
    if (end_req) begin
      chk("issues_left", iq.size(), 0);
      chk("dones_left", dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      start_v = '0;
      rst_v   = '0;
      hold_v  = 3'($urandom);
    end
  endtask

  // Schedule model: stage-major/pair-minor issue, hold stalls RUN edges only, DRAIN edges after each stage.
  task automatic run_xfer(input int i, input int hold_pct, input int hlo, input int hhi,
                          input int srel, input int rrel);
    bit h[1024];
    int t, e0, last, nn, dd, nst;
    iss_t it;
    dn_t  dn;
    nn  = NN[i];
    dd  = DD[i];
    nst = $clog2(nn);
    for (int k = 0; k < 1024; k++)
      h[k] = ($urandom_range(0, 99) < hold_pct) || (k >= hlo && k <= hhi);
    e0 = cyc + 1;
    t  = 1;
    for (int s = 0; s < nst; s++) begin
      for (int p = 0; p < nn / 2; p++) begin
        while (h[t] && t < 1000) t++;
        if (rrel == 0 || t < rrel) begin
          it = '{inst: i, edge_n: e0 + t, stage: s, pair: p};
          iq.push_back(it);
        end
        t++;
      end
      t += dd;
    end
    if (rrel == 0) begin
      dn = '{inst: i, edge_n: e0 + t, cnt: t};
      dq.push_back(dn);
    end
    bfrom[i] = e0;
    bto[i]   = (rrel != 0) ? e0 + rrel - 1 : e0 + t;
    last     = (rrel != 0) ? rrel : t;
    start_v[i] = 1'b1;
    hold_v[i]  = h[0];
    for (int rel = 1; rel <= last; rel++) begin
      @(posedge clk);
      #2;
      start_v[i] = (rel == srel) || (hold_pct > 0 && $urandom_range(0, 7) == 0);
      hold_v[i]  = h[rel];
      rst_v[i]   = (rel == rrel);
    end
    @(posedge clk);
    #2;
    start_v[i] = 1'b0;
    hold_v[i]  = 1'b0;
    rst_v[i]   = 1'b0;
  endtask

  initial begin
    start_v = '0;
    hold_v  = '0;
    rst_v   = '1;
    for (int i = 0; i < 3; i++) begin
      bfrom[i]  = 0;
      bto[i]    = -1;
      last_s[i] = 0;
      last_p[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst_v = '0;
    idle(2);
    run_xfer(0, 0, -1, -1, 0, 0);
    idle(2);
    run_xfer(1, 0, -1, -1, 0, 0);
    idle(2);
    run_xfer(1, 0, 3, 5, 0, 0);
    idle(2);
    run_xfer(0, 0, -1, -1, 9, 0);
    idle(2);
    run_xfer(0, 0, -1, -1, 0, 8);
    idle(1);
    run_xfer(0, 0, -1, -1, 0, 0);
    idle(2);
    run_xfer(2, 0, -1, -1, 0, 0);
    run_xfer(2, 0, -1, -1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        run_xfer(i, 25, -1, -1, 0, 0);
        idle($urandom_range(0, 2));
      end
    end
    for (int i = 0; i < 3; i++) begin
      run_xfer(i, 25, -1, -1, 0, $urandom_range(2, 12));
      idle(2);
      run_xfer(i, 20, -1, -1, 0, 0);
      idle(1);
    end
    idle(3);
    end_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL end: monitor did not reach summary");
    $fatal(1);
  end

endmodule
